// File: rtl/bicubic_frame_scheduler.sv
// Frame scheduler for a 4x vertical bicubic upscaler.
// Passes source pixels to the processing element (PE) and PE output words
// to the sink. It limits how many input rows may be accepted ahead of
// completed output row-groups, and tracks frame progress.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start                        one-cycle frame start request (IDLE only)
//   ac_upsp_rdata/rvalid, upsp_ac_rready        source pixel stream
//   pe_rdata/rvalid, pe_rready                  pixel stream to the PE
//   pe_wdata/wvalid, pe_wready                  4-pixel words from the PE
//   upsp_ac_wdata/wvalid/wlast/wsof, ac_upsp_wready   sink word stream
//   busy, done (pulse), ovf_err (sticky)        status
module bicubic_frame_scheduler #(
   parameter int unsigned SRC_W     = 960,
   parameter int unsigned SRC_H     = 540,
   parameter int unsigned LEAD_ROWS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] ac_upsp_rdata,
   input  logic        ac_upsp_rvalid,
   output logic        upsp_ac_rready,
   output logic [23:0] pe_rdata,
   output logic        pe_rvalid,
   input  logic        pe_rready,
   input  logic [95:0] pe_wdata,
   input  logic        pe_wvalid,
   output logic        pe_wready,
   output logic [95:0] upsp_ac_wdata,
   output logic        upsp_ac_wvalid,
   input  logic        ac_upsp_wready,
   output logic        upsp_ac_wlast,
   output logic        upsp_ac_wsof,
   output logic        busy,
   output logic        done,
   output logic        ovf_err
);

   localparam int unsigned COL_W  = $clog2(SRC_W);
   localparam int unsigned IROW_W = $clog2(SRC_H + 1);
   localparam int unsigned OROW_W = $clog2(4 * SRC_H);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

   state_e              state_q, state_d;
   logic [COL_W-1:0]    in_col_q, in_col_d;
   logic [IROW_W-1:0]   in_row_q, in_row_d;
   logic [COL_W-1:0]    out_col_q, out_col_d;
   logic [OROW_W-1:0]   out_row_q, out_row_d;
   logic [2:0]          rows_ahead_q, rows_ahead_d;
   logic                out_done_q, out_done_d;
   logic                ovf_q, ovf_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic in_en, out_en, in_hs, out_hs;
   logic in_col_last, out_col_last;
   logic in_row_end, in_frame_end, out_row_end, grp_end, out_frame_end;

   // Stream pass-through with flow gating
   always_comb begin
      in_en          = (state_q == RUN) && (rows_ahead_q < 3'(LEAD_ROWS));
      out_en         = (state_q == RUN) || (state_q == DRAIN);
      pe_rdata       = ac_upsp_rdata;
      pe_rvalid      = ac_upsp_rvalid & in_en;
      upsp_ac_rready = pe_rready & in_en;
      upsp_ac_wdata  = pe_wdata;
      upsp_ac_wvalid = pe_wvalid & out_en;
      pe_wready      = ac_upsp_wready & out_en;
      in_hs          = ac_upsp_rvalid & upsp_ac_rready;
      out_hs         = upsp_ac_wvalid & ac_upsp_wready;
      in_col_last    = (in_col_q == COL_W'(SRC_W - 1));
      out_col_last   = (out_col_q == COL_W'(SRC_W - 1));
      upsp_ac_wlast  = upsp_ac_wvalid & out_col_last;
      upsp_ac_wsof   = upsp_ac_wvalid & (out_col_q == '0) & (out_row_q == '0);
      in_row_end     = in_hs & in_col_last;
      in_frame_end   = in_row_end & (in_row_q == IROW_W'(SRC_H - 1));
      out_row_end    = out_hs & out_col_last;
      // One input row feeds a group of four output rows
      grp_end        = out_row_end & (out_row_q[1:0] == 2'd3);
      out_frame_end  = out_row_end & (out_row_q == OROW_W'(4 * SRC_H - 1));
   end

   // Next-state, counters and status
   always_comb begin
      state_d      = state_q;
      in_col_d     = in_col_q;
      in_row_d     = in_row_q;
      out_col_d    = out_col_q;
      out_row_d    = out_row_q;
      rows_ahead_d = rows_ahead_q;
      out_done_d   = out_done_q;
      ovf_d        = ovf_q;

      if (in_hs) begin
         in_col_d = in_col_last ? '0 : in_col_q + COL_W'(1);
         if (in_col_last) in_row_d = in_row_q + IROW_W'(1);
      end
      if (out_hs) begin
         out_col_d = out_col_last ? '0 : out_col_q + COL_W'(1);
         if (out_frame_end)    out_row_d = '0;
         else if (out_row_end) out_row_d = out_row_q + OROW_W'(1);
         if (out_frame_end) out_done_d = 1'b1;
         // PE produced a word with no input row in hand
         if ((rows_ahead_q == 3'd0) && (in_row_q < IROW_W'(SRC_H))) ovf_d = 1'b1;
      end
      // Simultaneous row-in and group-out cancel; never wrap below zero
      if (in_row_end && !grp_end)
         rows_ahead_d = rows_ahead_q + 3'd1;
      else if (grp_end && !in_row_end && (rows_ahead_q != 3'd0))
         rows_ahead_d = rows_ahead_q - 3'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d      = RUN;
               in_col_d     = '0;
               in_row_d     = '0;
               out_col_d    = '0;
               out_row_d    = '0;
               rows_ahead_d = '0;
               out_done_d   = 1'b0;
               ovf_d        = 1'b0;
            end
         end
         RUN:     if (in_frame_end) state_d = DRAIN;
         // Output may already have finished while still in RUN
         DRAIN:   if (out_frame_end || out_done_q) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
      done_d = (state_d == DONE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         in_col_q     <= '0;
         in_row_q     <= '0;
         out_col_q    <= '0;
         out_row_q    <= '0;
         rows_ahead_q <= '0;
         out_done_q   <= 1'b0;
         ovf_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_col_q     <= in_col_d;
         in_row_q     <= in_row_d;
         out_col_q    <= out_col_d;
         out_row_q    <= out_row_d;
         rows_ahead_q <= rows_ahead_d;
         out_done_q   <= out_done_d;
         ovf_q        <= ovf_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign ovf_err = ovf_q;

endmodule

// File: tb/tb_bicubic_frame_scheduler.sv
// Directed bench for bicubic_frame_scheduler on a 4x4 frame, LEAD_ROWS=1.
// A background process plays source, PE and sink; it scoreboards every
// handshake. The main initial block sequences the scenarios and asserts.
module tb_bicubic_frame_scheduler;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int LEAD = 1;
   localparam int NIN  = W * H;
   localparam int NOUT = W * 4 * H;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [23:0] ac_upsp_rdata, pe_rdata;
   logic        ac_upsp_rvalid, upsp_ac_rready, pe_rvalid, pe_rready;
   logic [95:0] pe_wdata, upsp_ac_wdata;
   logic        pe_wvalid, pe_wready, upsp_ac_wvalid, ac_upsp_wready;
   logic        upsp_ac_wlast, upsp_ac_wsof, busy, done, ovf_err;

   bicubic_frame_scheduler #(.SRC_W(W), .SRC_H(H), .LEAD_ROWS(LEAD)) dut (
      .clk(clk), .rst(rst), .start(start),
      .ac_upsp_rdata(ac_upsp_rdata), .ac_upsp_rvalid(ac_upsp_rvalid),
      .upsp_ac_rready(upsp_ac_rready),
      .pe_rdata(pe_rdata), .pe_rvalid(pe_rvalid), .pe_rready(pe_rready),
      .pe_wdata(pe_wdata), .pe_wvalid(pe_wvalid), .pe_wready(pe_wready),
      .upsp_ac_wdata(upsp_ac_wdata), .upsp_ac_wvalid(upsp_ac_wvalid),
      .ac_upsp_wready(ac_upsp_wready), .upsp_ac_wlast(upsp_ac_wlast),
      .upsp_ac_wsof(upsp_ac_wsof),
      .busy(busy), .done(done), .ovf_err(ovf_err)
   );

   always #5 clk = ~clk;

   // Environment controls and scoreboard state
   bit src_on = 1'b0, pe_gate = 1'b0;
   int sink_mode = 0;  // 0 never ready, 1 always ready, 2 random
   int cyc = 0, in_cnt = 0, out_cnt = 0, done_cnt = 0;
   int in_errs = 0, out_errs = 0, lead_errs = 0;
   int done_cyc = 0, last_out_cyc = 0;
   int n_chk = 0, n_pass = 0, n_fail = 0;

   // Source, PE and sink model: drive on negedge, score handshakes 1 ns later
   initial begin
      ac_upsp_rvalid = 1'b0; ac_upsp_rdata = '0; pe_rready = 1'b0;
      pe_wvalid = 1'b0; pe_wdata = '0; ac_upsp_wready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         ac_upsp_rvalid = src_on;
         ac_upsp_rdata  = 24'(in_cnt);
         pe_rready      = 1'b1;
         case (sink_mode)
            0:       ac_upsp_wready = 1'b0;
            1:       ac_upsp_wready = 1'b1;
            default: ac_upsp_wready = 1'($urandom_range(0, 1));
         endcase
         // A gated PE only emits words for row-groups whose input row arrived
         pe_wvalid = (out_cnt < NOUT) && (!pe_gate || (out_cnt / (4 * W) < in_cnt / W));
         pe_wdata  = {3{32'(out_cnt)}};
         #1;
         if (done) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
         end
         if (pe_rvalid !== (ac_upsp_rvalid & upsp_ac_rready)) in_errs++;
         if (pe_wready !== (ac_upsp_wready & busy)) out_errs++;
         if (upsp_ac_rready && ((in_cnt / W - out_cnt / (4 * W)) >= LEAD)) lead_errs++;
         if (upsp_ac_rready && ac_upsp_rvalid) begin
            if (pe_rdata !== 24'(in_cnt)) in_errs++;
            in_cnt++;
         end
         if (upsp_ac_wvalid && ac_upsp_wready) begin
            if (upsp_ac_wdata !== {3{32'(out_cnt)}}) out_errs++;
            if (upsp_ac_wlast !== ((out_cnt % W) == (W - 1))) out_errs++;
            if (upsp_ac_wsof !== (out_cnt == 0)) out_errs++;
            last_out_cyc = cyc;
            out_cnt++;
         end else if (!upsp_ac_wvalid && (upsp_ac_wlast || upsp_ac_wsof)) begin
            out_errs++;
         end
      end
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #3;
   endtask

   task automatic clear_counts();
      in_cnt = 0; out_cnt = 0; done_cnt = 0;
      in_errs = 0; out_errs = 0; lead_errs = 0;
      done_cyc = 0; last_out_cyc = 0;
   endtask

   task automatic pulse_start();
      step();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) step();
      repeat (2) step();
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_in_cnt"},   in_cnt,   NIN);
      check({tag, "_out_cnt"},  out_cnt,  NOUT);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_in_errs"},  in_errs,  0);
      check({tag, "_out_errs"}, out_errs, 0);
      check({tag, "_lead"},     lead_errs, 0);
      check({tag, "_done_lat"}, done_cyc - last_out_cyc, 1);
      check({tag, "_busy_end"}, int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0;
      // Reset with all inputs offering traffic
      src_on = 1'b1; sink_mode = 1; pe_gate = 1'b0;
      repeat (2) step();
      check("rst_busy",   int'(busy), 0);
      check("rst_done",   int'(done), 0);
      check("rst_ovf",    int'(ovf_err), 0);
      check("rst_rready", int'(upsp_ac_rready), 0);
      check("rst_rvalid", int'(pe_rvalid), 0);
      check("rst_wvalid", int'(upsp_ac_wvalid), 0);
      check("rst_wready", int'(pe_wready), 0);
      rst = 1'b0;
      step();
      check("idle_rready", int'(upsp_ac_rready), 0);
      check("idle_wvalid", int'(upsp_ac_wvalid), 0);

      // Nominal frame: source always valid, sink always ready
      clear_counts(); pe_gate = 1'b1;
      pulse_start();
      check("nom_busy", int'(busy), 1);
      wait_done(2000);
      check_frame("nom");
      check("nom_ovf", int'(ovf_err), 0);

      // Sink stalled: one row accepted, then source held off; stray start ignored
      clear_counts(); sink_mode = 0;
      pulse_start();
      repeat (30) step();
      check("stall_in_cnt", in_cnt, W);
      check("stall_rready", int'(upsp_ac_rready), 0);
      check("stall_out_cnt", out_cnt, 0);
      pulse_start();
      repeat (5) step();
      check("stray_busy", int'(busy), 1);
      check("stray_in_cnt", in_cnt, W);
      sink_mode = 1;
      wait_done(2000);
      check_frame("stall");

      // Random sink backpressure
      clear_counts(); sink_mode = 2;
      pulse_start();
      wait_done(4000);
      check_frame("rand");
      check("rand_ovf", int'(ovf_err), 0);

      // Reset mid-frame abandons the frame, then a clean frame follows
      clear_counts(); sink_mode = 1;
      pulse_start();
      repeat (6) step();
      rst = 1'b1;
      clear_counts();
      step();
      check("mid_rst_busy",   int'(busy), 0);
      check("mid_rst_rready", int'(upsp_ac_rready), 0);
      check("mid_rst_rvalid", int'(pe_rvalid), 0);
      check("mid_rst_wvalid", int'(upsp_ac_wvalid), 0);
      check("mid_rst_wready", int'(pe_wready), 0);
      rst = 1'b0;
      repeat (3) step();
      check("mid_rst_no_done", done_cnt, 0);
      pulse_start();
      wait_done(2000);
      check_frame("post_rst");

      // PE word with no input row in hand sets a sticky overflow
      clear_counts(); src_on = 1'b0; pe_gate = 1'b0;
      pulse_start();
      for (int i = 0; i < 20 && out_cnt == 0; i++) step();
      pe_gate = 1'b1; src_on = 1'b1;
      step();
      check("ovf_set", int'(ovf_err), 1);
      wait_done(2000);
      check_frame("ovf");
      repeat (3) step();
      check("ovf_sticky_idle", int'(ovf_err), 1);
      clear_counts();
      pulse_start();
      check("ovf_clear_on_start", int'(ovf_err), 0);
      wait_done(2000);
      check_frame("ovf_next");
      check("ovf_next_ovf", int'(ovf_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
